// File: rtl/code_serializer.sv
// code_serializer: buffers codewords in a small FIFO and sends each one as a
// framed serial packet (start, data LSB-first, optional parity, stop bits).
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous reset, active-high
//   in_valid  in   in_data holds a codeword
//   in_data   in   codeword [WIDTH-1:0]
//   in_ready  out  FIFO can accept a word (= !full, from registered count)
//   tx        out  serial line, idle high, registered
//   tx_busy   out  a frame is in progress
//   count     out  FIFO occupancy, 0..DEPTH
//
// Build option: define CODE_SERIALIZER_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit(s).
module code_serializer #(
    parameter int WIDTH     = 5,
    parameter int DEPTH     = 4,
    parameter int DIV       = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     tx,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BMAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int BW = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef CODE_SERIALIZER_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    // FIFO storage and pointers
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // transmitter state
    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_tx;
`ifdef CODE_SERIALIZER_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    state_t           w_state_nxt;
    logic [DW-1:0]    w_div_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_tx_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_nonempty;
    logic             w_bit_end;
    logic [WIDTH-1:0] w_head;

    // in_ready decodes only registered occupancy, so a pop in the same
    // cycle never opens the input combinationally.
    assign in_ready   = (r_count != CW'(DEPTH));
    assign w_push     = in_valid & in_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_bit_end  = (r_div == DW'(DIV - 1));

    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE);
    assign count   = r_count;

    // data array carries no reset; only pointers/count define contents
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

`ifdef CODE_SERIALIZER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif

        // divider runs in every frame state and restarts each bit period
        if (r_state != S_IDLE) begin
            w_div_nxt = w_bit_end ? '0 : r_div + 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
                    w_par_nxt   = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == BW'(WIDTH - 1)) begin
                        w_bit_nxt = '0;
`ifdef CODE_SERIALIZER_PARITY_EN
                        w_state_nxt = S_PAR;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
`ifdef CODE_SERIALIZER_PARITY_EN
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                    w_bit_nxt   = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == BW'(STOP_BITS - 1)) begin
                        w_bit_nxt = '0;
                        // chain straight into the next frame when data waits
                        if (w_nonempty) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_head;
                            w_state_nxt = S_START;
                            w_tx_nxt    = 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
                            w_par_nxt   = ^w_head;
`endif
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_code_serializer.sv
// tb_code_serializer: directed stimulus with a frame-decoding scoreboard
// for code_serializer (DIV=1 main instance, DIV=3 secondary instance).
module tb_code_serializer;

    localparam int W = 5;
    localparam int D = 4;
`ifdef CODE_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = 1 + W + P + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = '0;
    logic       in_ready, tx, tx_busy;
    logic [2:0] count;

    logic       d3_valid = 1'b0;
    logic [4:0] d3_data = '0;
    logic       d3_ready, d3_tx, d3_busy;
    logic [2:0] d3_count;

    always #5 clk = ~clk;

    code_serializer #(.WIDTH(W), .DEPTH(D), .DIV(1), .STOP_BITS(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .count    (count)
    );

    code_serializer #(.WIDTH(W), .DEPTH(D), .DIV(3), .STOP_BITS(1)) u_d3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (d3_valid),
        .in_data  (d3_data),
        .in_ready (d3_ready),
        .tx       (d3_tx),
        .tx_busy  (d3_busy),
        .count    (d3_count)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] w;
        logic       p;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   n_frames = 0;

    // frame decoder for the DIV=1 instance
    logic       m_act = 1'b0;
    int         m_pos = 0;
    logic [4:0] m_word;
    logic       m_par;
    exp_t       m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx == 1'b0) begin
                m_act  = 1'b1;
                m_pos  = 1;
                m_word = '0;
                m_par  = 1'b0;
                starts.push_back(cyc);
                check("start_busy", int'(tx_busy), 1);
            end
        end else begin
            if (m_pos <= W) begin
                m_word[m_pos-1] = tx;
            end else if (P == 1 && m_pos == W + 1) begin
                m_par = tx;
            end else begin
                check("stop_bit", int'(tx), 1);
                if (m_pos == FL - 1) begin
                    m_act = 1'b0;
                    n_frames++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got word %b, expected none",
                                 m_word);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("frame_word", int'(m_word), int'(m_e.w));
`ifdef CODE_SERIALIZER_PARITY_EN
                        check("frame_par", int'(m_par), int'(m_e.p));
`endif
                    end
                end
            end
            m_pos++;
        end
    end

    // per-cycle bit scoreboard for the DIV=3 instance
    logic d3_q[$];
    int   d3_busy_cyc = 0;

    always @(negedge clk) begin
        if (!rst && d3_busy) begin
            d3_busy_cyc++;
            if (d3_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d3_extra_bit: got busy tx %b, expected idle", d3_tx);
            end else begin
                check("d3_bit", int'(d3_tx), int'(d3_q.pop_front()));
            end
        end
    end

    // occupancy tracking
    int max_cnt      = 0;
    int full_blocked = 0;
    int bad_ready    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (int'(count) == D && !in_ready) full_blocked++;
            if (int'(count) == D && in_ready) bad_ready++;
        end
    end

    task automatic push(input logic [4:0] w, input logic p);
        exp_t e;
        logic acc;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 200 && !done; t++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.w = w;
                e.p = p;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got no accept for %b, expected accept", w);
        end
    endtask

    // hand-computed frame for 5'b01010: start, 0,1,0,1,0, [parity 0], stop
`ifdef CODE_SERIALIZER_PARITY_EN
    logic d3_bits [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic d3_bits [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    task automatic d3_push(input logic [4:0] w);
        logic acc;
        bit   done;
        done     = 1'b0;
        d3_valid = 1'b1;
        d3_data  = w;
        for (int t = 0; t < 200 && !done; t++) begin
            acc = d3_ready;
            @(posedge clk);
            if (acc) begin
                foreach (d3_bits[i]) begin
                    repeat (3) d3_q.push_back(d3_bits[i]);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        d3_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL d3_push_timeout: got no accept, expected accept");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (exp_q.size() != 0 || tx_busy); t++) begin
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int b;
    int base;
    int nf;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_d3_tx", int'(d3_tx), 1);
        rst = 1'b0;
        @(negedge clk);

        // single word, latency and busy length
        push(5'b10110, 1'b1);
        in_valid = 1'b0;
        check("t1_count_after_push", int'(count), 1);
        @(posedge clk);
        #1;
        check("t1_latency_tx", int'(tx), 0);
        check("t1_latency_busy", int'(tx_busy), 1);
        check("t1_count_after_pop", int'(count), 0);
        b = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx_busy) b++;
        end
        check("t1_busy_len", b, FL);

        // parity 0 word
        push(5'b00011, 1'b0);
        in_valid = 1'b0;
        drain();

        // back-to-back frames
        base = starts.size();
        push(5'b00001, 1'b1);
        push(5'b11111, 1'b1);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_frames", starts.size() - base, 2);
        if (starts.size() - base >= 2) begin
            check("t3_gap", starts[base+1] - starts[base], FL);
        end

        // hold valid through full FIFO
        max_cnt      = 0;
        full_blocked = 0;
        push(5'b10011, 1'b1);
        push(5'b01100, 1'b0);
        push(5'b11100, 1'b1);
        push(5'b00111, 1'b1);
        push(5'b10101, 1'b1);
        push(5'b01111, 1'b0);
        in_valid = 1'b0;
        drain();
        check("t4_max_count", max_cnt, D);
        check("t4_full_blocked", int'(full_blocked > 0), 1);

        // DIV=3 instance
        d3_busy_cyc = 0;
        d3_push(5'b01010);
        repeat (30) @(negedge clk);
        check("t5_frame_len", d3_busy_cyc, 3 * FL);
        check("t5_bits_left", d3_q.size(), 0);

        // reset mid-frame
        push(5'b11001, 1'b1);
        push(5'b00110, 1'b0);
        push(5'b01011, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_count_pre", int'(count), 2);
        check("t6_busy_pre", int'(tx_busy), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_tx", int'(tx), 1);
        check("t6_busy", int'(tx_busy), 0);
        check("t6_count", int'(count), 0);
        check("t6_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        nf = n_frames;
        repeat (30) @(negedge clk);
        check("t6_no_frames", n_frames - nf, 0);
        check("t6_tx_idle", int'(tx), 1);

        check("ready_when_full", bad_ready, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
